// File: rtl/uart_frame_decoder_if.sv
// Byte-in and packet-out streams of uart_frame_decoder, plus its error report.
// The master modport is the environment side; the slave modport is the decoder.
interface uart_frame_decoder_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] byte_in;
  logic                  byte_in_val;
  logic                  byte_in_rdy;
  logic [DATA_WIDTH-1:0] pkt_data;
  logic                  pkt_val;
  logic                  pkt_rdy;
  logic                  pkt_last;
  logic                  frame_err;
  logic [1:0]            err_code;

  modport master (
    output byte_in, byte_in_val, pkt_rdy,
    input  byte_in_rdy, pkt_data, pkt_val, pkt_last, frame_err, err_code
  );

  modport slave (
    input  byte_in, byte_in_val, pkt_rdy,
    output byte_in_rdy, pkt_data, pkt_val, pkt_last, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Hunts for SYNC, parses LEN/payload/CSUM, buffers the payload and releases it only on a good sum.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_decoder #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           MAX_PAYLOAD    = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
  parameter int unsigned           TIMEOUT_CYCLES = 1_000_000
) (
  input logic                   clk,
  input logic                   reset_n,
  uart_frame_decoder_if.slave   bus_io
);

  localparam int unsigned           IdxW   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [DATA_WIDTH-1:0] MaxLen = DATA_WIDTH'(MAX_PAYLOAD);

  if (DATA_WIDTH != 8 || MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255 || TIMEOUT_CYCLES < 2)
  begin : g_bad_param
    $error("uart_frame_decoder: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    StHunt,
    StLen,
    StPayload,
    StCheck,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                  frame_err_q, frame_err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [DATA_WIDTH-1:0] mem_q [MAX_PAYLOAD];

  logic acc;
  logic wr_en;
  logic drain_last;

  // byte_in_rdy is held low for the whole reset assertion, not just from the next edge.
  assign bus_io.byte_in_rdy = reset_n && (state_q != StDrain);
  assign acc                = bus_io.byte_in_val && bus_io.byte_in_rdy;
  assign drain_last         = (rd_idx_q == len_q - 1'b1);

  assign bus_io.pkt_val   = (state_q == StDrain);
  assign bus_io.pkt_last  = (state_q == StDrain) && drain_last;
  assign bus_io.pkt_data  = (state_q == StDrain) ? mem_q[rd_idx_q[IdxW-1:0]] : '0;
  assign bus_io.frame_err = frame_err_q;
  assign bus_io.err_code  = err_code_q;

`ifdef UART_FRAME_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_active;
  logic        tmo_expire;

  assign tmo_active = (state_q == StLen) || (state_q == StPayload) || (state_q == StCheck);
  // An accepted byte in the expiry cycle takes priority over the timeout.
  assign tmo_expire = tmo_active && !acc && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q + 32'd1;
    if (!tmo_active || acc) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    wr_en       = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (acc && bus_io.byte_in == SYNC_BYTE) begin
          state_d = StLen;
        end
      end
      StLen: begin
        if (acc) begin
          if (bus_io.byte_in == '0 || bus_io.byte_in > MaxLen) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = StHunt;
          end else begin
            len_d   = bus_io.byte_in;
            sum_d   = bus_io.byte_in;
            idx_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (acc) begin
          wr_en = 1'b1;
          sum_d = sum_q + bus_io.byte_in;
          idx_d = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (acc) begin
          if (bus_io.byte_in == sum_q) begin
            rd_idx_d = '0;
            state_d  = StDrain;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
            state_d     = StHunt;
          end
        end
      end
      StDrain: begin
        if (bus_io.pkt_rdy) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (drain_last) begin
            state_d = StHunt;
          end
        end
      end
      default: state_d = StHunt;
    endcase

`ifdef UART_FRAME_TIMEOUT_EN
    if (tmo_expire) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      state_d     = StHunt;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHunt;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload storage needs no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx_q[IdxW-1:0]] <= bus_io.byte_in;
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: directed frames push expected packet bytes and
// error codes; a negedge monitor pops and compares whatever the decoder presents.
module tb_uart_frame_decoder;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  uart_frame_decoder_if #(.DATA_WIDTH(8)) bus ();

  uart_frame_decoder #(
    .DATA_WIDTH     (8),
    .MAX_PAYLOAD    (16),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] exp_pkt_q [$];  // {last, data}
  logic [1:0] exp_err_q [$];
  logic [7:0] seq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_pkt(input logic [7:0] d, input logic last);
    exp_pkt_q.push_back({last, d});
  endtask

  // Drives seq byte by byte, returning #1 after the edge that accepted the last byte.
  task automatic send_seq();
    logic accepted;
    int   waited;
    foreach (seq[i]) begin
      bus.byte_in     = seq[i];
      bus.byte_in_val = 1'b1;
      waited          = 0;
      do begin
        @(negedge clk);
        accepted = bus.byte_in_rdy;
        @(posedge clk);
        #1;
        waited++;
      end while (!accepted && waited < 1000);
      if (!accepted) begin
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout: got rdy=0, expected rdy=1 within 1000 cycles");
      end
    end
    bus.byte_in_val = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: samples at negedge, when inputs and outputs are settled for the coming edge.
  logic       prev_stall;
  logic [8:0] prev_out;
  initial prev_stall = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall) begin
        check("pkt_hold_val", 32'(bus.pkt_val), 32'd1);
        check("pkt_hold_data", 32'({bus.pkt_last, bus.pkt_data}), 32'(prev_out));
      end
      if (bus.pkt_val) begin
        check("rdy_low_in_drain", 32'(bus.byte_in_rdy), 32'd0);
        if (exp_pkt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt: got data %0h, expected no pkt_val", bus.pkt_data);
        end else if (bus.pkt_rdy) begin
          check("pkt_data_last", 32'({bus.pkt_last, bus.pkt_data}), 32'(exp_pkt_q.pop_front()));
        end
      end
      if (bus.frame_err) begin
        if (exp_err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got code %0d, expected no frame_err", bus.err_code);
        end else begin
          check("err_code", 32'(bus.err_code), 32'(exp_err_q.pop_front()));
        end
      end
      prev_stall = bus.pkt_val && !bus.pkt_rdy;
      prev_out   = {bus.pkt_last, bus.pkt_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int waited;
    checks          = 0;
    errors          = 0;
    bus.byte_in     = '0;
    bus.byte_in_val = 1'b0;
    bus.pkt_rdy     = 1'b1;
    reset_n         = 1'b0;
    #12;
    check("rst_rdy", 32'(bus.byte_in_rdy), 32'd0);
    check("rst_outs", 32'({bus.pkt_val, bus.pkt_last, bus.frame_err, bus.err_code,
                           bus.pkt_data}), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("hunt_rdy", 32'(bus.byte_in_rdy), 32'd1);
    idle(2);

    // Basic frame; first byte the cycle after CSUM, then one byte per cycle.
    push_pkt(8'h11, 1'b0);
    push_pkt(8'h22, 1'b0);
    push_pkt(8'h33, 1'b1);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq();
    check("latency_val", 32'(bus.pkt_val), 32'd1);
    idle(3);
    check("drain_3_cycles", 32'(bus.pkt_val), 32'd0);

    // Bad checksum, then a single-byte frame.
    exp_err_q.push_back(2'd2);
    seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_seq();
    push_pkt(8'h7F, 1'b1);
    seq = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    send_seq();
    idle(3);

    // Junk before sync, oversize length, zero length.
    exp_err_q.push_back(2'd1);
    seq = '{8'hFF, 8'h00, 8'hA5, 8'h11, 8'h01, 8'h02};
    send_seq();
    exp_err_q.push_back(2'd1);
    seq = '{8'hA5, 8'h00};
    send_seq();
    idle(3);

    // Full-size frame with a 5-cycle stall mid-drain; the next frame (with A5 payload)
    // is offered throughout the drain and must be held off, not lost.
    for (int i = 0; i < 16; i++) push_pkt(8'hF0, i == 15);
    seq = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) seq.push_back(8'hF0);
    seq.push_back(8'h10);
    send_seq();
    push_pkt(8'hA5, 1'b0);
    push_pkt(8'hA5, 1'b1);
    fork
      begin
        idle(4);
        bus.pkt_rdy = 1'b0;
        idle(5);
        bus.pkt_rdy = 1'b1;
      end
      begin
        seq = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};
        send_seq();
      end
    join
    idle(4);

    // Reset mid-payload: outputs clear at once, no error, then a clean frame decodes.
    seq = '{8'hA5, 8'h03, 8'h01};
    send_seq();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_outs", 32'({bus.byte_in_rdy, bus.pkt_val, bus.pkt_last, bus.frame_err,
                              bus.err_code, bus.pkt_data}), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_pkt(8'hFF, 1'b0);
    push_pkt(8'h03, 1'b1);
    seq = '{8'hA5, 8'h02, 8'hFF, 8'h03, 8'h04};
    send_seq();
    idle(4);

`ifdef UART_FRAME_TIMEOUT_EN
    exp_err_q.push_back(2'd3);
    seq = '{8'hA5, 8'h03, 8'h11};
    send_seq();
    idle(100);
    idle(3);
    check("tmo_back_to_hunt", 32'(bus.byte_in_rdy), 32'd1);
`endif

    // Inter-byte stall: just under the timeout, or far beyond it with no timeout built in.
    push_pkt(8'h01, 1'b0);
    push_pkt(8'h02, 1'b1);
    seq = '{8'hA5, 8'h02, 8'h01};
    send_seq();
`ifdef UART_FRAME_TIMEOUT_EN
    idle(98);
`else
    idle(150);
`endif
    seq = '{8'h02, 8'h05};
    send_seq();

    waited = 0;
    while ((exp_pkt_q.size() != 0 || exp_err_q.size() != 0) && waited < 2000) begin
      idle(1);
      waited++;
    end
    idle(5);
    check("pkt_queue_empty", 32'(exp_pkt_q.size()), 32'd0);
    check("err_queue_empty", 32'(exp_err_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
